// File: rtl/mem_be_ctrl.sv
// Single-port synchronous memory with byte strobes, a post-reset/on-demand scrub,
// out-of-range detection and configurable read latency behind a valid/ready handshake.
module mem_be_ctrl #(
  parameter int              WIDTH        = 16,
  parameter int              DEPTH        = 64,
  parameter int              ADDR_WIDTH   = $clog2(DEPTH),
  parameter int              READ_LATENCY = 1,
  parameter logic [WIDTH-1:0] FILL_VALUE  = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  input  logic                  wr_rd_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic [WIDTH/8-1:0]    strb_i,
  input  logic                  clr_i,
  output logic [WIDTH-1:0]      rdata_o,
  output logic                  ready_o,
  output logic                  err_o,
  output logic                  busy_o
);

  localparam int NB = WIDTH / 8;
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  // Terminal count of the RD wait; unreachable when READ_LATENCY is 1.
  localparam logic [1:0]            LAT_LAST  = 2'(READ_LATENCY - 2);

  generate
    if ((WIDTH % 8) != 0 || READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_param
      $error("mem_be_ctrl: WIDTH must be a multiple of 8 and READ_LATENCY in 1..4");
    end
  endgenerate

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_RD, S_ACK} state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_oor;
  logic [1:0]            r_lat;

  logic [WIDTH-1:0] mem [0:DEPTH-1];

  logic                  w_in_oor;
  logic                  w_acc_wr;
  logic                  w_acc_rd;
  logic                  w_rd_done;
  logic                  w_rd_oor;
  logic [ADDR_WIDTH-1:0] w_rd_addr;
  logic [NB-1:0]         w_we;
  logic [ADDR_WIDTH-1:0] w_waddr;
  logic [WIDTH-1:0]      w_wdata;

  assign w_in_oor  = ({1'b0, addr_i} >= DEPTH_EXT);
  assign w_acc_wr  = (r_state == S_IDLE) && !clr_i && valid_i && wr_rd_i;
  assign w_acc_rd  = (r_state == S_IDLE) && !clr_i && valid_i && !wr_rd_i;
  assign w_rd_done = ((r_state == S_RD) && (r_lat == LAT_LAST)) ||
                     (w_acc_rd && (READ_LATENCY == 1));
  // A latency-1 read takes its address straight from the request.
  assign w_rd_addr = (r_state == S_IDLE) ? addr_i : r_addr;
  assign w_rd_oor  = (r_state == S_IDLE) ? w_in_oor : r_oor;

  // Single write port shared by the scrub sequence and strobed host writes.
  always_comb begin
    w_we    = '0;
    w_waddr = addr_i;
    w_wdata = wdata_i;
    if (r_state == S_INIT) begin
      w_we    = '1;
      w_waddr = r_cnt;
      w_wdata = FILL_VALUE;
    end else if (w_acc_wr && !w_in_oor) begin
      w_we = strb_i;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NB; k++) begin
      if (w_we[k]) begin
        mem[w_waddr][8*k +: 8] <= w_wdata[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_INIT;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_oor   <= 1'b0;
      r_lat   <= '0;
      rdata_o <= '0;
      ready_o <= 1'b0;
      err_o   <= 1'b0;
      busy_o  <= 1'b1;
    end else begin
      ready_o <= 1'b0;
      err_o   <= 1'b0;
      if (w_rd_done) begin
        rdata_o <= w_rd_oor ? '0 : mem[w_rd_addr];
      end
      case (r_state)
        S_INIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_ADDR) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
            busy_o  <= 1'b0;
          end
        end
        S_IDLE: begin
          if (clr_i) begin
            r_state <= S_INIT;
            r_cnt   <= '0;
            busy_o  <= 1'b1;
          end else if (w_acc_wr) begin
            r_state <= S_ACK;
            ready_o <= 1'b1;
            err_o   <= w_in_oor;
          end else if (w_acc_rd) begin
            r_addr <= addr_i;
            r_oor  <= w_in_oor;
            r_lat  <= '0;
            if (READ_LATENCY == 1) begin
              r_state <= S_ACK;
              ready_o <= 1'b1;
              err_o   <= w_in_oor;
            end else begin
              r_state <= S_RD;
            end
          end
        end
        S_RD: begin
          if (r_lat == LAT_LAST) begin
            r_state <= S_ACK;
            ready_o <= 1'b1;
            err_o   <= r_oor;
          end else begin
            r_lat <= r_lat + 2'd1;
          end
        end
        S_ACK: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_INIT;
          r_cnt   <= '0;
          busy_o  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_be_ctrl.sv
// Directed bench: u_a (DEPTH 64, latency 1, fill DEAD) and u_b (DEPTH 48, latency 3,
// fill 5A5A) share one clock; expected values are hand-derived constants or a shadow array.
module tb_mem_be_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   [2];
  logic        valid [2];
  logic        wr    [2];
  logic [5:0]  addr  [2];
  logic [15:0] wdata [2];
  logic [1:0]  strb  [2];
  logic        clr   [2];
  logic [15:0] rdata [2];
  logic        ready [2];
  logic        err   [2];
  logic        busy  [2];

  int n_checks = 0;
  int n_errors = 0;

  mem_be_ctrl #(.WIDTH(16), .DEPTH(64), .READ_LATENCY(1), .FILL_VALUE(16'hDEAD)) u_a (
    .clk_i(clk), .rst_i(rst[0]), .valid_i(valid[0]), .wr_rd_i(wr[0]), .addr_i(addr[0]),
    .wdata_i(wdata[0]), .strb_i(strb[0]), .clr_i(clr[0]), .rdata_o(rdata[0]),
    .ready_o(ready[0]), .err_o(err[0]), .busy_o(busy[0]));

  mem_be_ctrl #(.WIDTH(16), .DEPTH(48), .READ_LATENCY(3), .FILL_VALUE(16'h5A5A)) u_b (
    .clk_i(clk), .rst_i(rst[1]), .valid_i(valid[1]), .wr_rd_i(wr[1]), .addr_i(addr[1]),
    .wdata_i(wdata[1]), .strb_i(strb[1]), .clr_i(clr[1]), .rdata_o(rdata[1]),
    .ready_o(ready[1]), .err_o(err[1]), .busy_o(busy[1]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One request on instance i; returns data, error flag and edges from accept to ready.
  task automatic xfer(input int i, input logic w, input logic [5:0] a, input logic [15:0] d,
                      input logic [1:0] s, output logic [15:0] rd, output logic e,
                      output int lat);
    @(posedge clk); #1;
    valid[i] = 1'b1; wr[i] = w; addr[i] = a; wdata[i] = d; strb[i] = s;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!ready[i] && lat < 20);
    check("ready_seen", 32'(ready[i]), 32'd1);
    rd = rdata[i];
    e  = err[i];
    valid[i] = 1'b0;
    @(posedge clk); #1;
    check("ready_one_cycle", 32'(ready[i]), 32'd0);
    $display("[%0t] u%0d %s addr=%02h wdata=%04h strb=%b -> rdata=%04h err=%0b lat=%0d",
             $time, i, w ? "WR" : "RD", a, d, s, rd, e, lat);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd;
    logic        e;
    int          lat;
    int          na, nb, ra, npulse, n;
    logic [15:0] ra_data;
    logic        ra_err;
    logic [15:0] exp_mem [64];

    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; valid[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0;
      wdata[i] = '0; strb[i] = '0; clr[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdata", 32'(rdata[0]), 32'd0);
    check("rst_ready", 32'(ready[0]), 32'd0);
    check("rst_err",   32'(err[0]),   32'd0);
    check("rst_busy_a", 32'(busy[0]), 32'd1);
    check("rst_busy_b", 32'(busy[1]), 32'd1);

    // Read of 3F is held through the scrub and must be accepted right after busy falls.
    valid[0] = 1'b1; wr[0] = 1'b0; addr[0] = 6'h3F;
    rst[0] = 1'b0; rst[1] = 1'b0;
    na = 0; nb = 0; ra = 0; npulse = 0; ra_data = '0; ra_err = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      if (!busy[0] && na == 0) na = c;
      if (!busy[1] && nb == 0) nb = c;
      if (ready[0]) begin
        npulse++;
        if (ra == 0) begin
          ra = c; ra_data = rdata[0]; ra_err = err[0];
        end
        valid[0] = 1'b0;
      end
    end
    $display("[%0t] u0 INIT busy_edges=%0d u1 busy_edges=%0d first read at edge %0d rdata=%04h",
             $time, na, nb, ra, ra_data);
    check("init_busy_a", 32'(na), 32'd64);
    check("init_busy_b", 32'(nb), 32'd48);
    check("init_read_edge", 32'(ra), 32'd65);
    check("init_read_data", 32'(ra_data), 32'hDEAD);
    check("init_read_err", 32'(ra_err), 32'd0);
    check("init_pulses", 32'(npulse), 32'd1);

    // Byte strobes
    xfer(0, 1'b1, 6'h05, 16'hA5C3, 2'b11, rd, e, lat);
    check("strb_wr_err", 32'(e), 32'd0);
    check("strb_wr_lat", 32'(lat), 32'd1);
    xfer(0, 1'b1, 6'h05, 16'h1200, 2'b10, rd, e, lat);
    xfer(0, 1'b1, 6'h05, 16'hFFFF, 2'b00, rd, e, lat);
    check("strb_zero_err", 32'(e), 32'd0);
    xfer(0, 1'b0, 6'h05, 16'h0000, 2'b00, rd, e, lat);
    check("strb_rd_data", 32'(rd), 32'h12C3);
    check("strb_rd_err", 32'(e), 32'd0);
    check("strb_rd_lat", 32'(lat), 32'd1);

    // Full sweep
    for (int a = 0; a < 64; a++) begin
      exp_mem[a] = 16'($urandom);
      xfer(0, 1'b1, 6'(a), exp_mem[a], 2'b11, rd, e, lat);
    end
    for (int a = 0; a < 64; a++) begin
      xfer(0, 1'b0, 6'(a), 16'h0000, 2'b00, rd, e, lat);
      check("sweep_data", 32'(rd), 32'(exp_mem[a]));
      check("sweep_err", 32'(e), 32'd0);
    end

    // Clear on request
    xfer(0, 1'b1, 6'h10, 16'h1234, 2'b11, rd, e, lat);
    xfer(0, 1'b0, 6'h10, 16'h0000, 2'b00, rd, e, lat);
    check("clr_pre_data", 32'(rd), 32'h1234);
    @(posedge clk); #1;
    clr[0] = 1'b1;
    @(posedge clk); #1;
    clr[0] = 1'b0;
    check("clr_busy_rise", 32'(busy[0]), 32'd1);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (busy[0] && n < 200);
    $display("[%0t] u0 CLR busy_edges=%0d", $time, n);
    check("clr_busy_edges", 32'(n), 32'd64);
    xfer(0, 1'b0, 6'h10, 16'h0000, 2'b00, rd, e, lat);
    check("clr_data_10", 32'(rd), 32'hDEAD);
    xfer(0, 1'b0, 6'h05, 16'h0000, 2'b00, rd, e, lat);
    check("clr_data_05", 32'(rd), 32'hDEAD);

    // Latency 3 and out-of-range on u_b
    xfer(1, 1'b0, 6'h00, 16'h0000, 2'b00, rd, e, lat);
    check("lat_data", 32'(rd), 32'h5A5A);
    check("lat_edges", 32'(lat), 32'd3);
    xfer(1, 1'b1, 6'd47, 16'h4747, 2'b11, rd, e, lat);
    check("oor_47_wr_err", 32'(e), 32'd0);
    check("oor_wr_lat", 32'(lat), 32'd1);
    xfer(1, 1'b1, 6'd50, 16'h1111, 2'b11, rd, e, lat);
    check("oor_50_wr_err", 32'(e), 32'd1);
    xfer(1, 1'b0, 6'd47, 16'h0000, 2'b00, rd, e, lat);
    check("oor_47_rd_data", 32'(rd), 32'h4747);
    check("oor_47_rd_err", 32'(e), 32'd0);
    xfer(1, 1'b0, 6'd50, 16'h0000, 2'b00, rd, e, lat);
    check("oor_50_rd_data", 32'(rd), 32'h0000);
    check("oor_50_rd_err", 32'(e), 32'd1);
    check("oor_50_rd_lat", 32'(lat), 32'd3);
    xfer(1, 1'b0, 6'd2, 16'h0000, 2'b00, rd, e, lat);
    check("oor_no_alias", 32'(rd), 32'h5A5A);

    // Reset while a read sits in RD
    xfer(1, 1'b1, 6'd3, 16'h7777, 2'b11, rd, e, lat);
    xfer(1, 1'b0, 6'd3, 16'h0000, 2'b00, rd, e, lat);
    check("mid_pre_data", 32'(rd), 32'h7777);
    @(posedge clk); #1;
    valid[1] = 1'b1; wr[1] = 1'b0; addr[1] = 6'd3;
    @(posedge clk); #1;
    check("mid_rd_no_ready", 32'(ready[1]), 32'd0);
    rst[1] = 1'b1;
    #1;
    valid[1] = 1'b0;
    check("mid_rst_rdata", 32'(rdata[1]), 32'd0);
    check("mid_rst_ready", 32'(ready[1]), 32'd0);
    check("mid_rst_err", 32'(err[1]), 32'd0);
    check("mid_rst_busy", 32'(busy[1]), 32'd1);
    npulse = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (ready[1]) npulse++;
    end
    check("mid_rst_pulses", 32'(npulse), 32'd0);
    rst[1] = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (busy[1] && n < 200);
    $display("[%0t] u1 RST-in-RD busy_edges=%0d", $time, n);
    check("mid_busy_edges", 32'(n), 32'd48);
    xfer(1, 1'b0, 6'd3, 16'h0000, 2'b00, rd, e, lat);
    check("mid_scrubbed", 32'(rd), 32'h5A5A);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
